// File: rtl/ledsuit_pkg.sv
// Shared types and helpers for the LED suit display pipeline.
// Holds the scheduler state encoding and microsecond-to-cycle conversion.
package ledsuit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SWAP  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_LATCH = 3'd4
    } fsm_state_t;

    localparam int NUM_DRIVERS_DEF = 8;

    function automatic int us_to_cyc(input int us, input int mhz);
        return us * mhz;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/frame_scheduler_sat_timer.sv
// Saturating up-counter: load a start value, count toward a limit and hold there.
// o_done is high whenever the count has reached the limit.
module sat_timer #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_count,
    input  logic [W-1:0] i_limit,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    assign o_done = (r_cnt >= i_limit);

    // Counter register: load wins over count, count stops at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_count && (r_cnt < i_limit)) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// Double-buffered frame sequencer: commits SPI frames, swaps banks when drivers are idle,
// staggers driver start pulses, then enforces the latch gap and minimum frame period.
module frame_scheduler
    import ledsuit_pkg::*;
#(
    parameter int NUM_DRIVERS    = NUM_DRIVERS_DEF,
    parameter int CLOCK_RATE_MHZ = 50,
    parameter int LATCH_US       = 300,
    parameter int MIN_FRAME_US   = 10000,
    parameter int STAGGER_CYC    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   spi_selected,
    input  logic                   spi_done,
    input  logic [NUM_DRIVERS-1:0] drv_busy,
    output logic [NUM_DRIVERS-1:0] drv_start,
    output logic                   rd_bank,
    output logic                   wr_bank,
    output logic                   frame_pending,
    output logic [15:0]            frame_count,
    output logic [7:0]             overrun_count
);

    localparam int LATCH_CYC  = us_to_cyc(LATCH_US, CLOCK_RATE_MHZ);
    localparam int PERIOD_CYC = max_int(us_to_cyc(MIN_FRAME_US, CLOCK_RATE_MHZ), 1);
    localparam int LAT_LIM_I  = max_int(LATCH_CYC - 1, 0);
    localparam int STG_LIM_I  = max_int(STAGGER_CYC - 1, 0);
    localparam int LAT_W      = $clog2(max_int(LAT_LIM_I, STG_LIM_I) + 2);
    localparam int PER_W      = $clog2(PERIOD_CYC + 1);
    localparam int IDX_W      = (NUM_DRIVERS > 1) ? $clog2(NUM_DRIVERS) : 1;

    localparam logic [LAT_W-1:0]       LAT_LIM  = LAT_W'(LAT_LIM_I);
    localparam logic [LAT_W-1:0]       STG_LIM  = LAT_W'(STG_LIM_I);
    localparam logic [LAT_W-1:0]       LAT_ZERO = LAT_W'(0);
    localparam logic [PER_W-1:0]       PER_LIM  = PER_W'(PERIOD_CYC);
    localparam logic [PER_W-1:0]       PER_ONE  = PER_W'(1);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_DRIVERS - 1);
    localparam logic [NUM_DRIVERS-1:0] DRV_ONE  = NUM_DRIVERS'(1);

    fsm_state_t             r_state;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_guard;
    logic [NUM_DRIVERS-1:0] r_drv_start;
    logic                   r_rd_bank;
    logic                   r_wr_bank;
    logic [15:0]            r_frame_count;
    logic                   r_sel_q;
    logic [1:0]             r_byte_cnt;
    logic                   r_pending;
    logic [7:0]             r_overrun;

    logic                   w_sel_fall;
    logic                   w_commit;
    logic                   w_go;
    logic                   w_lat_load;
    logic                   w_lat_done;
    logic [LAT_W-1:0]       w_lat_limit;
    logic                   w_per_done;

    assign w_sel_fall = r_sel_q & ~spi_selected;
    assign w_commit   = w_sel_fall & (r_byte_cnt != 2'd0);

    // Waiting for sel_q to drop as well keeps a commit from ever landing on the SWAP cycle.
    assign w_go = (r_state == ST_IDLE) & r_pending & enable & w_per_done
                  & ~spi_selected & ~r_sel_q;

    // One counter serves both the stagger spacing in START and the latch gap in LATCH.
    assign w_lat_load  = ((r_state != ST_START) && (r_state != ST_LATCH))
                         || ((r_state == ST_START) && w_lat_done);
    assign w_lat_limit = (r_state == ST_LATCH) ? LAT_LIM : STG_LIM;

    sat_timer #(
        .W       (LAT_W),
        .RST_VAL (LAT_ZERO)
    ) u_lat_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_lat_load),
        .i_load_val (LAT_ZERO),
        .i_count    (1'b1),
        .i_limit    (w_lat_limit),
        .o_done     (w_lat_done)
    );

    // Loaded with 1 on the way into SWAP so the SWAP cycle itself counts toward the period.
    sat_timer #(
        .W       (PER_W),
        .RST_VAL (PER_LIM)
    ) u_period_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_go),
        .i_load_val (PER_ONE),
        .i_count    (1'b1),
        .i_limit    (PER_LIM),
        .o_done     (w_per_done)
    );

    // SPI transaction tracking: byte counter, pending flag and overrun statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_q    <= 1'b0;
            r_byte_cnt <= 2'd0;
            r_pending  <= 1'b0;
            r_overrun  <= 8'd0;
        end else begin
            r_sel_q <= spi_selected;
            if (w_sel_fall) begin
                r_byte_cnt <= 2'd0;
            end else if (spi_selected && spi_done && (r_byte_cnt != 2'd3)) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
            end else begin
                r_byte_cnt <= r_byte_cnt;
            end
            if (w_commit) begin
                r_pending <= 1'b1;
            end else if (r_state == ST_SWAP) begin
                r_pending <= 1'b0;
            end else begin
                r_pending <= r_pending;
            end
            if (w_commit && r_pending && (r_overrun != 8'hFF)) begin
                r_overrun <= r_overrun + 8'd1;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    // Frame sequencing FSM with registered bank selects and start pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_guard       <= 1'b0;
            r_drv_start   <= '0;
            r_rd_bank     <= 1'b0;
            r_wr_bank     <= 1'b1;
            r_frame_count <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_drv_start <= '0;
                    if (w_go) begin
                        r_state <= ST_SWAP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SWAP: begin
                    r_rd_bank     <= ~r_rd_bank;
                    r_wr_bank     <= r_rd_bank;
                    r_frame_count <= r_frame_count + 16'd1;
                    r_idx         <= '0;
                    r_drv_start   <= DRV_ONE;
                    r_state       <= ST_START;
                end
                ST_START: begin
                    if (r_idx == LAST_IDX) begin
                        r_drv_start <= '0;
                        r_guard     <= 1'b1;
                        r_state     <= ST_RUN;
                    end else if (w_lat_done) begin
                        r_drv_start <= DRV_ONE << (r_idx + 1'b1);
                        r_idx       <= r_idx + 1'b1;
                    end else begin
                        r_drv_start <= '0;
                    end
                end
                ST_RUN: begin
                    r_drv_start <= '0;
                    // The last driver only raises busy one cycle after its pulse.
                    if (r_guard) begin
                        r_guard <= 1'b0;
                    end else if (drv_busy == '0) begin
                        r_state <= ST_LATCH;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_LATCH: begin
                    r_drv_start <= '0;
                    if (w_lat_done) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_LATCH;
                    end
                end
                default: begin
                    r_drv_start <= '0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign drv_start     = r_drv_start;
    assign rd_bank       = r_rd_bank;
    assign wr_bank       = r_wr_bank;
    assign frame_pending = r_pending;
    assign frame_count   = r_frame_count;
    assign overrun_count = r_overrun;

endmodule
